w0rm_peripheral_charlcd_fifo: RTL



---
 rtl/w0rm_peripheral_charlcd_fifo.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/w0rm_peripheral_charlcd_fifo.sv
// HD44780-class character LCD controller with a command/data FIFO on the W0RM bus.
// Define CHARLCD_BUSY_POLL_EN to replace the fixed post-byte delay with busy-flag polling.
module w0rm_peripheral_charlcd_fifo #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h4000_0000,
    parameter int                    BUS_WIDTH   = 4,
    parameter int                    FIFO_DEPTH  = 8,
    parameter int                    T_SETUP     = 6,
    parameter int                    T_EN_HIGH   = 45,
    parameter int                    T_EN_CYCLE  = 100,
    parameter int                    T_EXEC      = 2000,
    parameter int                    T_EXEC_LONG = 80000
) (
    input  logic                  mem_clk,
    input  logic                  cpu_reset,
    input  logic                  mem_valid_i,
    input  logic                  mem_read_i,
    input  logic                  mem_write_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output logic                  mem_valid_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic                  lcd_rs,
    output logic                  lcd_rw,
    output logic                  lcd_en,
    output logic [BUS_WIDTH-1:0]  lcd_data_o,
    input  logic [BUS_WIDTH-1:0]  lcd_data_i,
    output logic                  lcd_data_oe
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(T_EXEC_LONG + T_EXEC + T_EN_CYCLE + T_SETUP + 1) + 1;
    localparam logic [ADDR_WIDTH:0] W_LO = {1'b0, BASE_ADDR};
    localparam logic [ADDR_WIDTH:0] W_HI = W_LO + (ADDR_WIDTH+1)'(16);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_EN_HI, S_EN_LO, S_EXEC} state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [7:0]            r_byte;
    logic                  r_is_data;
    logic                  r_second;
    logic                  r_mem_valid;
    logic [DATA_WIDTH-1:0] r_mem_data;
    logic                  r_enable;
    logic                  r_overflow;
    logic [8:0]            r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [LVL_W-1:0]      r_level;
    logic                  r_lcd_rs;
    logic                  r_lcd_rw;
    logic                  r_lcd_en;
    logic [BUS_WIDTH-1:0]  r_lcd_data;
    logic                  r_lcd_oe;

    logic                  w_hit;
    logic                  w_wr;
    logic [1:0]            w_sel;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_ready;
    logic                  w_pop;
    logic                  w_push_req;
    logic                  w_push;
    logic                  w_flush;
    logic [8:0]            w_head;
    logic                  w_reading;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_unused;

`ifdef CHARLCD_BUSY_POLL_EN
    logic                  r_rd;
    logic [7:0]            r_stat;
    logic [7:0]            r_status;
    assign w_reading = r_rd;
`else
    logic                  w_long;
    assign w_reading = 1'b0;
    // Clear-display and return-home need the long execution time.
    assign w_long = !r_is_data && (r_byte[7:2] == 6'd0) && (r_byte[1:0] != 2'd0);
`endif

    assign w_unused   = &{1'b0, lcd_data_i, mem_data_i[DATA_WIDTH-1:8]};
    assign w_hit      = mem_valid_i && (mem_read_i || mem_write_i) &&
                        ({1'b0, mem_addr_i} >= W_LO) && ({1'b0, mem_addr_i} < W_HI);
    assign w_wr       = w_hit && mem_write_i;
    assign w_sel      = mem_addr_i[3:2];
    assign w_full     = (r_level == LVL_W'(FIFO_DEPTH));
    assign w_empty    = (r_level == '0);
    assign w_ready    = w_empty && (r_state == S_IDLE);
    assign w_pop      = (r_state == S_IDLE) && r_enable && !w_empty;
    assign w_push_req = w_wr && ((w_sel == 2'd1) || (w_sel == 2'd2));
    // A pop in the same cycle frees the slot, so a push into a full queue still lands.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_flush    = w_wr && (w_sel == 2'd0) && mem_data_i[4];
    assign w_head     = r_fifo[r_rd_ptr];

    always_comb begin
        w_rdata = '0;
        case (w_sel)
            2'd0: begin
                w_rdata[0]           = r_enable;
                w_rdata[1]           = w_ready;
                w_rdata[2]           = w_full;
                w_rdata[3]           = r_overflow;
                w_rdata[8 +: LVL_W]  = r_level;
            end
`ifdef CHARLCD_BUSY_POLL_EN
            2'd3: w_rdata[7:0] = r_status;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge mem_clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= {(w_sel == 2'd2), mem_data_i[7:0]};
    end

    always_ff @(posedge mem_clk) begin
        if (cpu_reset) begin
            r_mem_valid <= 1'b0;
            r_mem_data  <= '0;
            r_enable    <= 1'b0;
            r_overflow  <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
        end else begin
            r_mem_valid <= w_hit;
            r_mem_data  <= (w_hit && mem_read_i) ? w_rdata : '0;
            if (w_wr && (w_sel == 2'd0)) r_enable <= mem_data_i[0];
            if (w_push_req && !w_push) r_overflow <= 1'b1;
            else if (w_wr && (w_sel == 2'd0) && mem_data_i[3]) r_overflow <= 1'b0;
            // Flush discards the queue; a byte popped this cycle is already owned by the FSM.
            if (w_flush) begin
                r_rd_ptr <= r_wr_ptr;
                r_level  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
                case ({w_push, w_pop})
                    2'b10:   r_level <= r_level + 1'b1;
                    2'b01:   r_level <= r_level - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge mem_clk) begin
        if (cpu_reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_byte     <= '0;
            r_is_data  <= 1'b0;
            r_second   <= 1'b0;
            r_lcd_rs   <= 1'b0;
            r_lcd_rw   <= 1'b0;
            r_lcd_en   <= 1'b0;
            r_lcd_data <= '0;
            r_lcd_oe   <= 1'b0;
`ifdef CHARLCD_BUSY_POLL_EN
            r_rd       <= 1'b0;
            r_stat     <= '0;
            r_status   <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_byte     <= w_head[7:0];
                        r_is_data  <= w_head[8];
                        r_lcd_rs   <= w_head[8];
                        r_lcd_rw   <= 1'b0;
                        r_lcd_oe   <= 1'b1;
                        r_lcd_data <= w_head[7 -: BUS_WIDTH];
                        r_second   <= 1'b0;
                        r_cnt      <= '0;
                        r_state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (r_cnt == CNT_W'(T_SETUP - 1)) begin
                        r_lcd_en <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= S_EN_HI;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                // r_cnt keeps counting from the EN rise through EN_LO to pace the next rise.
                S_EN_HI: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(T_EN_HIGH - 1)) begin
                        r_lcd_en <= 1'b0;
                        r_state  <= S_EN_LO;
`ifdef CHARLCD_BUSY_POLL_EN
                        if (r_rd) r_stat <= 8'({r_stat, lcd_data_i});
`endif
                        if ((BUS_WIDTH == 4) && !r_second && !w_reading)
                            r_lcd_data <= r_byte[BUS_WIDTH-1:0];
                    end
                end
                S_EN_LO: begin
                    if (r_cnt == CNT_W'(T_EN_CYCLE - 1)) begin
                        r_cnt <= '0;
                        if ((BUS_WIDTH == 4) && !r_second) begin
                            r_second <= 1'b1;
                            r_lcd_en <= 1'b1;
                            r_state  <= S_EN_HI;
`ifdef CHARLCD_BUSY_POLL_EN
                        end else if (r_rd) begin
                            r_status <= r_stat;
                            r_lcd_rw <= 1'b0;
                            if (r_stat[7]) begin
                                r_state <= S_EXEC;
                            end else begin
                                r_rd    <= 1'b0;
                                r_state <= S_IDLE;
                            end
`endif
                        end else begin
                            r_lcd_oe   <= 1'b0;
                            r_lcd_rs   <= 1'b0;
                            r_lcd_data <= '0;
                            r_state    <= S_EXEC;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_EXEC: begin
`ifdef CHARLCD_BUSY_POLL_EN
                    // Each busy poll is a full read transfer through the normal EN timing.
                    r_lcd_rw <= 1'b1;
                    r_lcd_rs <= 1'b0;
                    r_lcd_oe <= 1'b0;
                    r_rd     <= 1'b1;
                    r_second <= 1'b0;
                    r_cnt    <= '0;
                    r_state  <= S_SETUP;
`else
                    if (r_cnt == (w_long ? CNT_W'(T_EXEC_LONG - 1) : CNT_W'(T_EXEC - 1))) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_valid_o = r_mem_valid;
    assign mem_data_o  = r_mem_data;
    assign lcd_rs      = r_lcd_rs;
    assign lcd_rw      = r_lcd_rw;
    assign lcd_en      = r_lcd_en;
    assign lcd_data_o  = r_lcd_data;
    assign lcd_data_oe = r_lcd_oe;

endmodule
